// File: rtl/spi_master_mcs.sv
// 3-wire SPI master: shared sdio, N chip selects, programmable sclk divider.
// Frame is r_w, address, data (MSB first); busy/done/err status.
module spi_master_mcs #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 16,
    parameter int N_CS    = 4,
    parameter int CS_W    = (N_CS > 1) ? $clog2(N_CS) : 1,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               r_w,
    input  logic [CS_W-1:0]    cs_sel,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] w_data,
    output logic [D_WIDTH-1:0] r_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               sclk,
    output logic [N_CS-1:0]    cs_n,
    inout  wire                sdio
);

    localparam int NB   = 1 + A_WIDTH + D_WIDTH;
    localparam int BC_W = $clog2(NB);
    localparam int DV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(NB - 1);
    localparam logic [BC_W-1:0] LAST_ADDR = BC_W'(A_WIDTH);
    localparam logic [DV_W-1:0] DIV_END   = DV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t            state;
    logic [DV_W-1:0]   div_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [NB-1:0]     sh;
    logic [D_WIDTH-1:0] rx;
    logic              rd;
    logic              bad;
    logic              sdio_oe;
    logic              sel_bad;

    assign sel_bad = 32'(cs_sel) >= 32'(N_CS);

    // The outgoing bit is always the MSB of the frame shifter.
    assign sdio = sdio_oe ? sh[NB-1] : 1'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            rx      <= '0;
            rd      <= 1'b0;
            bad     <= 1'b0;
            sdio_oe <= 1'b0;
            sclk    <= 1'b0;
            cs_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            r_data  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT;
                        sh      <= {r_w, addr, w_data};
                        rd      <= r_w;
                        bad     <= sel_bad;
                        cs_n    <= sel_bad ? '1 : ~(N_CS'(1) << cs_sel);
                        busy    <= 1'b1;
                        sdio_oe <= 1'b1;
                        sclk    <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_END) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            if (rd && bit_cnt > LAST_ADDR)
                                rx <= {rx[D_WIDTH-2:0], sdio};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                state   <= HOLD;
                                sdio_oe <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                sh      <= {sh[NB-2:0], 1'b0};
                                // Hand the line to the slave for the data phase.
                                if (rd && bit_cnt == LAST_ADDR)
                                    sdio_oe <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (div_cnt != DIV_END) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        state   <= IDLE;
                        cs_n    <= '1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= bad;
                        if (rd && !bad)
                            r_data <= rx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
